// File: rtl/request_resolver_if.sv
// Call/controller bundle between the elevator controller side (master) and the
// request resolver (slave).
interface request_resolver_if #(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_BITS = 3
);
    logic [NUM_FLOORS-1:0] btn;
    logic [FLOOR_BITS-1:0] floor;
    logic                  up;
    logic                  down;
    logic                  open;
    logic [FLOOR_BITS-1:0] req;
    logic [NUM_FLOORS-1:0] pending;
    logic                  busy;

    modport master (
        output btn, floor, up, down, open,
        input  req, pending, busy
    );

    modport slave (
        input  btn, floor, up, down, open,
        output req, pending, busy
    );
endinterface

// File: rtl/request_resolver.sv
// Holds floor calls as pending requests and presents one SCAN-ordered target
// floor at a time to the elevator controller.
module request_resolver #(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_BITS = 3
) (
    input logic               clk,
    input logic               resetN,
    request_resolver_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StScanUp,
        StScanDown
    } dir_e;

    dir_e                  dir_q;
    logic [FLOOR_BITS-1:0] req_q;
    logic [NUM_FLOORS-1:0] pending_q;
    logic [NUM_FLOORS-1:0] pending_d;
    logic                  busy_q;

    logic                  ctl_idle;
    logic [NUM_FLOORS-1:0] floor_hit;
    logic [NUM_FLOORS-1:0] masked;
    logic                  a_found;
    logic                  b_found;
    logic [FLOOR_BITS-1:0] a_floor;
    logic [FLOOR_BITS-1:0] b_floor;

    // Any non-zero (up, down, open) combination, legal or not, counts as busy.
    assign ctl_idle = ~(bus.up | bus.down | bus.open);

    always_comb begin
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            floor_hit[i] = (bus.floor == FLOOR_BITS'(i));
        end
    end

    // Presses at the current floor while open or idle are dropped: the car
    // is already there and the controller never opens for target == floor.
    always_comb begin
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (bus.open && floor_hit[i]) begin
                pending_d[i] = 1'b0;
            end else if (bus.btn[i] && !(floor_hit[i] && (bus.open || ctl_idle))) begin
                pending_d[i] = 1'b1;
            end else begin
                pending_d[i] = pending_q[i];
            end
        end
    end

    assign masked = pending_q & ~floor_hit;

    // A: nearest pending call above the car; B: nearest pending call below.
    always_comb begin
        a_found = 1'b0;
        a_floor = '0;
        b_found = 1'b0;
        b_floor = '0;
        for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
            if (masked[i] && (FLOOR_BITS'(i) > bus.floor)) begin
                a_found = 1'b1;
                a_floor = FLOOR_BITS'(i);
            end
        end
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (masked[i] && (FLOOR_BITS'(i) < bus.floor)) begin
                b_found = 1'b1;
                b_floor = FLOOR_BITS'(i);
            end
        end
    end

    // Target only changes while the controller is idle, so it is never
    // pre-empted mid-travel or with the door open.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dir_q     <= StIdle;
            req_q     <= '0;
            pending_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            busy_q    <= |pending_d;
            if (ctl_idle) begin
                case (dir_q)
                    StScanDown: begin
                        if (b_found) begin
                            req_q <= b_floor;
                        end else if (a_found) begin
                            req_q <= a_floor;
                            dir_q <= StScanUp;
                        end else begin
                            dir_q <= StIdle;
                        end
                    end
                    // StIdle and StScanUp both favour calls above the car.
                    default: begin
                        if (a_found) begin
                            req_q <= a_floor;
                            dir_q <= StScanUp;
                        end else if (b_found) begin
                            req_q <= b_floor;
                            dir_q <= StScanDown;
                        end else begin
                            dir_q <= StIdle;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.req     = req_q;
    assign bus.pending = pending_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_request_resolver.sv
// Self-checking bench for request_resolver: vector table, hand-written service
// sequences, async reset, and randomized traffic against a floor-list model.
module tb_request_resolver;

    localparam int NF = 8;
    localparam int FB = 3;

    logic clk = 1'b0;
    logic resetN;

    request_resolver_if #(.NUM_FLOORS(NF), .FLOOR_BITS(FB)) bus ();

    request_resolver #(.NUM_FLOORS(NF), .FLOOR_BITS(FB)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: pending calls as a bit list, direction as 0/1/2.
    bit [NF-1:0] m_pend;
    int          m_req;
    int          m_dir;  // 0 idle, 1 scanning up, 2 scanning down
    bit          m_busy;

    typedef struct {
        bit [7:0] btn;
        int       floor;
        bit       up;
        bit       down;
        bit       open;
        int       req;
        bit [7:0] pend;
        bit       busy;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_req  = 0;
        m_dir  = 0;
        m_busy = 1'b0;
    endtask

    function automatic int find_above(input bit [NF-1:0] p, input int f);
        for (int i = f + 1; i < NF; i++) if (p[i]) return i;
        return -1;
    endfunction

    function automatic int find_below(input bit [NF-1:0] p, input int f);
        for (int i = f - 1; i >= 0; i--) if (p[i]) return i;
        return -1;
    endfunction

    task automatic model_clock();
        int          f;
        bit          idle;
        bit [NF-1:0] nxt;
        int          a;
        int          b;
        f    = int'(bus.floor);
        idle = !(bus.up || bus.down || bus.open);
        nxt  = m_pend;
        for (int i = 0; i < NF; i++) begin
            if (bus.btn[i] && !(f == i && (bus.open || idle))) nxt[i] = 1'b1;
            if (bus.open && f == i) nxt[i] = 1'b0;
        end
        if (idle) begin
            a = find_above(m_pend, f);
            b = find_below(m_pend, f);
            if (m_dir == 2) begin
                if (b >= 0) m_req = b;
                else if (a >= 0) begin m_req = a; m_dir = 1; end
                else m_dir = 0;
            end else begin
                if (a >= 0) begin m_req = a; m_dir = 1; end
                else if (b >= 0) begin m_req = b; m_dir = 2; end
                else m_dir = 0;
            end
        end
        m_pend = nxt;
        m_busy = (nxt != 0);
    endtask

    task automatic compare_model();
        check("model_req", 32'(bus.req), 32'(m_req));
        check("model_pending", 32'(bus.pending), 32'(m_pend));
        check("model_busy", 32'(bus.busy), 32'(m_busy));
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        compare_model();
    endtask

    task automatic drive(input bit [7:0] b, input int f, input bit u, input bit d, input bit o);
        bus.btn   = b;
        bus.floor = 3'(f);
        bus.up    = u;
        bus.down  = d;
        bus.open  = o;
        step();
    endtask

    task automatic do_reset();
        bus.btn  = '0;
        bus.up   = 1'b0;
        bus.down = 1'b0;
        bus.open = 1'b0;
        resetN   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    initial begin
        tbl = '{
            '{8'h20, 0, 0, 0, 0, 5, 8'h20, 1},
            '{8'h00, 0, 0, 0, 0, 5, 8'h20, 1},
            '{8'h00, 0, 1, 0, 0, 5, 8'h20, 1},
            '{8'h00, 5, 0, 0, 1, 5, 8'h00, 0},
            '{8'h00, 5, 0, 0, 0, 5, 8'h00, 0},
            '{8'h08, 3, 0, 0, 0, 5, 8'h00, 0},
            '{8'h90, 4, 0, 0, 1, 5, 8'h80, 1},
            '{8'h00, 4, 0, 0, 0, 7, 8'h80, 1},
            '{8'h52, 4, 1, 0, 0, 7, 8'hD2, 1},
            '{8'h00, 7, 0, 0, 1, 7, 8'h52, 1},
            '{8'h00, 7, 0, 0, 0, 6, 8'h52, 1},
            '{8'h00, 6, 0, 0, 1, 6, 8'h12, 1},
            '{8'h00, 6, 0, 0, 0, 4, 8'h12, 1},
            '{8'h00, 4, 0, 0, 1, 4, 8'h02, 1},
            '{8'h00, 4, 0, 0, 0, 1, 8'h02, 1},
            '{8'h00, 1, 0, 0, 1, 1, 8'h00, 0},
            '{8'h00, 1, 0, 0, 0, 1, 8'h00, 0}
        };
        // Row 0 pending appears first; req=5 follows one cycle later.
        tbl[0].req = 0;

        bus.btn   = '0;
        bus.floor = '0;
        bus.up    = 1'b0;
        bus.down  = 1'b0;
        bus.open  = 1'b0;
        resetN    = 1'b0;
        model_reset();
        #2;
        check("reset_req", 32'(bus.req), 0);
        check("reset_pending", 32'(bus.pending), 0);
        check("reset_busy", 32'(bus.busy), 0);
        do_reset();

        for (int k = 0; k < 17; k++) begin
            drive(tbl[k].btn, tbl[k].floor, tbl[k].up, tbl[k].down, tbl[k].open);
            check($sformatf("tbl%0d_req", k), 32'(bus.req), 32'(tbl[k].req));
            check($sformatf("tbl%0d_pending", k), 32'(bus.pending), 32'(tbl[k].pend));
            check($sformatf("tbl%0d_busy", k), 32'(bus.busy), 32'(tbl[k].busy));
        end

        // Idle at floor 2 with calls {1,4,6}: served 4, 6, then 1.
        do_reset();
        drive(8'h52, 2, 0, 0, 0);
        check("scan_pend", 32'(bus.pending), 32'h52);
        drive(8'h00, 2, 0, 0, 0);
        check("scan_first", 32'(bus.req), 4);
        drive(8'h00, 3, 1, 0, 0);
        drive(8'h00, 4, 0, 0, 1);
        drive(8'h00, 4, 0, 0, 0);
        check("scan_second", 32'(bus.req), 6);
        drive(8'h00, 5, 1, 0, 0);
        drive(8'h00, 6, 0, 0, 1);
        drive(8'h00, 6, 0, 0, 0);
        check("scan_third", 32'(bus.req), 1);

        // Call behind the car during travel does not pre-empt the target.
        do_reset();
        drive(8'h40, 0, 0, 0, 0);
        drive(8'h00, 0, 0, 0, 0);
        check("travel_target", 32'(bus.req), 6);
        drive(8'h00, 1, 1, 0, 0);
        drive(8'h00, 2, 1, 0, 0);
        drive(8'h04, 3, 1, 0, 0);
        check("travel_pend", 32'(bus.pending), 32'h44);
        drive(8'h00, 4, 1, 0, 0);
        drive(8'h00, 5, 1, 0, 0);
        check("travel_hold", 32'(bus.req), 6);
        drive(8'h00, 6, 0, 0, 1);
        drive(8'h00, 6, 0, 0, 0);
        check("travel_reverse", 32'(bus.req), 2);

        // Asynchronous reset mid-travel clears everything without a clock edge.
        do_reset();
        drive(8'h81, 3, 0, 0, 0);
        drive(8'h00, 3, 0, 0, 0);
        drive(8'h00, 4, 1, 0, 0);
        check("async_pre_pend", 32'(bus.pending), 32'h81);
        #2;
        resetN = 1'b0;
        #1;
        check("async_req", 32'(bus.req), 0);
        check("async_pending", 32'(bus.pending), 0);
        check("async_busy", 32'(bus.busy), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        for (int k = 0; k < 4; k++) drive(8'h00, 4, 0, 0, 0);
        check("async_no_req", 32'(bus.req), 0);

        // Randomized traffic, including illegal multi-hot controller states.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bit [7:0] b;
            int       r;
            bit [2:0] c;
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            r = $urandom_range(0, 9);
            if (r < 5) c = 3'b000;
            else if (r == 5) c = 3'b100;
            else if (r == 6) c = 3'b010;
            else if (r < 9) c = 3'b001;
            else c = 3'($urandom);
            drive(b, $urandom_range(0, NF - 1), c[2], c[1], c[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
